servo_motion_ctrl: RTL and testbench

Motion controller for the servo PWM path. It accepts target angles (0–180°) over a valid/ready handshake and ramps the commanded angle toward the target at a programmable rate, one step per N PWM frames. It converts the angle to a pulse width in clocks with a sequential multiplier. It owns the 20 ms frame timebase and presents `high_dur`/`total_dur` to the PWM generator, changing `high_dur` only at frame boundaries so no output pulse is ever truncated.

---
 rtl/servo_pkg.sv | 24 ++
 rtl/servo_motion_ctrl_if.sv | 21 ++
 rtl/servo_pulse_mult.sv | 47 ++++
 rtl/servo_motion_ctrl.sv | 139 +++++++++++++
 tb/tb_servo_motion_ctrl.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// Shared types and constants for the servo motion controller.
// Timing defaults assume a 50 MHz clock and a 20 ms frame.
package servo_pkg;

  localparam int ANGLE_MAX      = 180;
  localparam int DEF_DUR_CLOCKS = 1000000;
  localparam int DEF_PULSE_MIN  = 25000;
  localparam int DEF_PULSE_MAX  = 125000;
  localparam int DEF_INIT_ANGLE = 90;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    CALC = 2'd2
  } servo_state_e;

  function automatic logic [31:0] calc_k(
    input int pmin,
    input int pmax
  );
    return 32'((pmax - pmin) / ANGLE_MAX);
  endfunction

endpackage

// File: rtl/servo_motion_ctrl_if.sv
// Target-angle valid/ready channel into the motion controller.
// The requester drives valid/angle; the controller drives ready.
interface servo_motion_ctrl_if;

  logic       tgt_valid;
  logic       tgt_ready;
  logic [7:0] tgt_angle;

  modport master (
    output tgt_valid,
    output tgt_angle,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_angle,
    output tgt_ready
  );

endinterface

// File: rtl/servo_pulse_mult.sv
// 8x32 sequential shift-add multiplier, one bit per clock.
// done pulses for one cycle, 8 iterations after start.
module servo_pulse_mult (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  angle,
  input  logic [31:0] k,
  output logic        done,
  output logic [31:0] product
);

  logic [7:0]  a;
  logic [31:0] b;
  logic [2:0]  cnt;
  logic        run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      b       <= '0;
      cnt     <= '0;
      run     <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a       <= angle;
        b       <= k;
        cnt     <= '0;
        run     <= 1'b1;
        product <= '0;
      end else if (run) begin
        if (a[0]) product <= product + b;
        a   <= a >> 1;
        b   <= b << 1;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/servo_motion_ctrl.sv
// Servo motion controller: frame timebase, angle ramp and
// pulse-width update applied only on frame boundaries.
module servo_motion_ctrl
  import servo_pkg::*;
#(
  parameter int DUR_CLOCKS  = DEF_DUR_CLOCKS,
  parameter int PULSE_MIN   = DEF_PULSE_MIN,
  parameter int PULSE_MAX   = DEF_PULSE_MAX,
  parameter int INIT_ANGLE  = DEF_INIT_ANGLE,
  parameter int STEP_DEG    = 1,
  parameter int STEP_FRAMES = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  servo_motion_ctrl_if.slave  tgt,
  output logic [31:0]         high_dur,
  output logic [31:0]         total_dur,
  output logic                frame_tick,
  output logic [7:0]          cur_angle,
  output logic                busy
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_MOVE = MOVE;
  localparam logic [1:0] S_CALC = CALC;

  localparam logic [31:0] K        = calc_k(PULSE_MIN, PULSE_MAX);
  localparam logic [31:0] PMIN     = 32'(PULSE_MIN);
  localparam logic [31:0] INIT_DUR =
    32'(PULSE_MIN + INIT_ANGLE * int'(K));
  localparam logic [7:0]  INIT_A   = 8'(INIT_ANGLE);
  localparam logic [7:0]  AMAX     = 8'(ANGLE_MAX);
  localparam logic [7:0]  STEP_U   = 8'(STEP_DEG);
  localparam logic signed [8:0] STEP_S = 9'(STEP_DEG);
  localparam logic [31:0] FR_LAST  = 32'(STEP_FRAMES - 1);
  localparam logic [31:0] CNT_LAST = 32'(DUR_CLOCKS - 1);

  logic [1:0]  state;
  logic [31:0] cnt;
  logic [31:0] div;
  logic [31:0] pending;
  logic [31:0] product;
  logic        pending_vld;
  logic        done;
  logic [7:0]  target;
  logic [7:0]  clamped;
  logic [7:0]  next_angle;
  logic signed [8:0] diff;
  logic        accept;
  logic        step_due;
  logic        step;
  logic        apply;

  assign total_dur     = 32'(DUR_CLOCKS);
  assign frame_tick    = (cnt == CNT_LAST);
  assign tgt.tgt_ready = (state != S_CALC);
  assign accept        = tgt.tgt_valid && tgt.tgt_ready;
  assign clamped       = (tgt.tgt_angle > AMAX) ? AMAX
                                                : tgt.tgt_angle;
  assign busy          = (state != S_IDLE) || pending_vld;
  assign apply         = frame_tick && pending_vld;

  // signed 9-bit distance keeps the ramp from wrapping at 0/180
  assign diff = $signed({1'b0, target})
              - $signed({1'b0, cur_angle});

  assign step_due = (state == S_MOVE) && frame_tick
                 && (div == FR_LAST);
  assign step     = step_due && (diff != '0);

  always_comb begin
    next_angle = target;
    if (diff > STEP_S)
      next_angle = cur_angle + STEP_U;
    else if (diff < -STEP_S)
      next_angle = cur_angle - STEP_U;
  end

  servo_pulse_mult u_mult (
    .clk     (clk),
    .rst_n   (reset_n),
    .start   (step),
    .angle   (next_angle),
    .k       (K),
    .done    (done),
    .product (product)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      state       <= S_IDLE;
      div         <= '0;
      cur_angle   <= INIT_A;
      target      <= INIT_A;
      pending     <= '0;
      pending_vld <= 1'b0;
      high_dur    <= INIT_DUR;
    end else begin
      cnt <= frame_tick ? '0 : cnt + 32'd1;
      if (accept) target <= clamped;
      if (apply) begin
        high_dur    <= pending;
        pending_vld <= 1'b0;
      end
      unique case (1'b1)
        state == S_IDLE: begin
          if (accept && clamped != cur_angle) begin
            state <= S_MOVE;
            div   <= '0;
          end
        end
        state == S_MOVE: begin
          if (step_due) begin
            div <= '0;
            if (step) begin
              cur_angle <= next_angle;
              state     <= S_CALC;
            end else begin
              state <= S_IDLE;
            end
          end else if (frame_tick) begin
            div <= div + 32'd1;
          end
        end
        state == S_CALC: begin
          // a new result outranks the clear from a same-cycle apply
          if (done) begin
            pending     <= PMIN + product;
            pending_vld <= 1'b1;
            state <= (cur_angle != target) ? S_MOVE : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Self-checking bench for servo_motion_ctrl with a frame-level
// reference model of targets, ramp steps and deferred updates.
module tb_servo_motion_ctrl;
  import servo_pkg::*;

  localparam int DUR  = 200;
  localparam int PMIN = 25000;
  localparam int PMAX = 125000;
  localparam int KK   = (PMAX - PMIN) / 180;
  localparam int SD[2] = '{1, 4};
  localparam int SF[2] = '{1, 3};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  servo_motion_ctrl_if ifa ();
  servo_motion_ctrl_if ifb ();

  logic [31:0] hd_a, hd_b, td_a, td_b;
  logic        ft_a, ft_b, bz_a, bz_b;
  logic [7:0]  ca_a, ca_b;

  servo_motion_ctrl #(.DUR_CLOCKS(DUR)) dut_a (
    .clk(clk), .reset_n(reset_n), .tgt(ifa),
    .high_dur(hd_a), .total_dur(td_a), .frame_tick(ft_a),
    .cur_angle(ca_a), .busy(bz_a)
  );

  servo_motion_ctrl #(
    .DUR_CLOCKS(DUR), .STEP_DEG(4), .STEP_FRAMES(3)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .tgt(ifb),
    .high_dur(hd_b), .total_dur(td_b), .frame_tick(ft_b),
    .cur_angle(ca_b), .busy(bz_b)
  );

  int errors = 0;
  int checks = 0;

  int m_cur[2], m_tgt[2], m_high[2], m_pend[2], m_div[2];
  bit m_vld[2], m_mov[2];
  int m_cnt;
  bit last_dtick;

  function automatic int pulse(input int a);
    return PMIN + a * KK;
  endfunction

  function automatic int clamp(input int a);
    return (a > ANGLE_MAX) ? ANGLE_MAX : a;
  endfunction

  function automatic int toward(input int c, input int t,
                                input int s);
    if (t - c > s) return c + s;
    if (c - t > s) return c - s;
    return t;
  endfunction

  function automatic bit m_busy(input int s);
    return m_mov[s] || m_vld[s];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_cur[s]  = 90;
      m_tgt[s]  = 90;
      m_high[s] = pulse(90);
      m_pend[s] = 0;
      m_div[s]  = 0;
      m_vld[s]  = 0;
      m_mov[s]  = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_tick(input int s);
    if (m_vld[s]) begin
      m_high[s] = m_pend[s];
      m_vld[s]  = 0;
    end
    if (m_mov[s]) begin
      m_div[s]++;
      if (m_div[s] == SF[s]) begin
        m_div[s] = 0;
        if (m_cur[s] == m_tgt[s]) begin
          m_mov[s] = 0;
        end else begin
          m_cur[s]  = toward(m_cur[s], m_tgt[s], SD[s]);
          m_pend[s] = pulse(m_cur[s]);
          m_vld[s]  = 1;
          if (m_cur[s] == m_tgt[s]) m_mov[s] = 0;
        end
      end
    end
  endtask

  task automatic model_accept(input int s, input int a);
    m_tgt[s] = clamp(a);
    if (!m_mov[s] && m_tgt[s] != m_cur[s]) begin
      m_mov[s] = 1;
      m_div[s] = 0;
    end
  endtask

  // one clock: entered and left on a falling edge
  task automatic clk_step(input int s, input bit v, input int a,
                          output bit tick, output bit acc);
    ifa.tgt_valid = (s == 0) && v;
    ifb.tgt_valid = (s == 1) && v;
    ifa.tgt_angle = 8'(a);
    ifb.tgt_angle = 8'(a);
    tick = (m_cnt == DUR - 1);
    last_dtick = (s == 0) ? ft_a : ft_b;
    acc = v && ((s == 0) ? ifa.tgt_ready : ifb.tgt_ready);
    @(posedge clk);
    #1;
    m_cnt = tick ? 0 : m_cnt + 1;
    if (tick) begin
      model_tick(0);
      model_tick(1);
    end
    if (acc) model_accept(s, a);
    @(negedge clk);
  endtask

  task automatic send(input int s, input int a, output bit ok);
    bit t, acc;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      clk_step(s, 1, a, t, acc);
      ok = acc;
    end
    ifa.tgt_valid = 1'b0;
    ifb.tgt_valid = 1'b0;
  endtask

  task automatic do_reset();
    ifa.tgt_valid = 1'b0;
    ifb.tgt_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    ifa.tgt_valid = 1'b0;
    ifb.tgt_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ca_a !== 8'd90 || ca_b !== 8'd90) begin
      errors++;
      $display("FAIL reset_angle: got %0d/%0d expected 90",
               ca_a, ca_b);
    end
    checks++;
    if (hd_a !== 32'd74950 || hd_b !== 32'd74950) begin
      errors++;
      $display("FAIL reset_high: got %0d/%0d expected 74950",
               hd_a, hd_b);
    end
    checks++;
    if (td_a !== 32'd200 || td_b !== 32'd200) begin
      errors++;
      $display("FAIL reset_total: got %0d/%0d expected 200",
               td_a, td_b);
    end
    checks++;
    if (ifa.tgt_ready !== 1'b1 || ifb.tgt_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %0b/%0b expected 1",
               ifa.tgt_ready, ifb.tgt_ready);
    end
    checks++;
    if (bz_a !== 1'b0 || bz_b !== 1'b0 || ft_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_tick: got %0b/%0b/%0b expected 0",
               bz_a, bz_b, ft_a);
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_frame();
    bit t, acc;
    int nt = 0;
    for (int i = 0; i < 2 * DUR + 20; i++) begin
      clk_step(0, 0, 0, t, acc);
      if (t) nt++;
      checks++;
      if (last_dtick !== t) begin
        errors++;
        $display("FAIL frame_tick: cycle %0d got %0b expected %0b",
                 i, last_dtick, t);
      end
    end
    checks++;
    if (nt != 2) begin
      errors++;
      $display("FAIL frame_count: got %0d expected 2", nt);
    end
  endtask

  task automatic test_basic();
    int exp_cur[4] = '{91, 92, 93, 93};
    int exp_hd[4]  = '{74950, 75505, 76060, 76615};
    bit exp_bz[4]  = '{1, 1, 1, 0};
    bit t, acc, ok;
    int n = 0;
    do_reset();
    send(0, 90, ok);
    checks++;
    if (!ok || bz_a !== 1'b0) begin
      errors++;
      $display("FAIL same_angle: ok %0b busy %0b expected 1/0",
               ok, bz_a);
    end
    send(0, 93, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_accept: got timeout expected accept");
    end
    for (int c = 0; c < 5 * DUR && n < 4; c++) begin
      clk_step(0, 0, 0, t, acc);
      if (t) begin
        checks++;
        if (ca_a !== 8'(exp_cur[n]) || hd_a !== 32'(exp_hd[n])
            || bz_a !== exp_bz[n]) begin
          errors++;
          $display("FAIL basic_tick%0d: got %0d/%0d/%0b expected %0d/%0d/%0b",
                   n + 1, ca_a, hd_a, bz_a,
                   exp_cur[n], exp_hd[n], exp_bz[n]);
        end
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL basic_ticks: got %0d expected 4", n);
    end
  endtask

  task automatic test_clamp();
    bit t, acc, ok, rdy;
    int w = 0;
    int n = 0;
    do_reset();
    send(0, 200, ok);
    for (int c = 0; c < 2 * DUR && n == 0; c++) begin
      clk_step(0, 0, 0, t, acc);
      if (t) n++;
    end
    rdy = ifa.tgt_ready;
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL calc_ready: got %0b expected 0", rdy);
    end
    acc = 0;
    for (int c = 0; c < 40 && !acc; c++) begin
      clk_step(0, 1, 200, t, acc);
      if (!acc) w++;
    end
    ifa.tgt_valid = 1'b0;
    checks++;
    if (!acc || w < 8 || w > 10) begin
      errors++;
      $display("FAIL calc_hold: got %0d wait cycles expected 8..10",
               w);
    end
    for (int c = 0; c < 100 * DUR && m_busy(0); c++) begin
      clk_step(0, 0, 0, t, acc);
      if (t) begin
        checks++;
        if (ca_a !== 8'(m_cur[0]) || hd_a !== 32'(m_high[0])) begin
          errors++;
          $display("FAIL clamp_ramp: got %0d/%0d expected %0d/%0d",
                   ca_a, hd_a, m_cur[0], m_high[0]);
        end
      end
    end
    checks++;
    if (ca_a !== 8'd180 || hd_a !== 32'd124900 || bz_a !== 1'b0)
    begin
      errors++;
      $display("FAIL clamp_end: got %0d/%0d/%0b expected 180/124900/0",
               ca_a, hd_a, bz_a);
    end
  endtask

  task automatic test_step4();
    int got_q[$];
    int exp_q[$];
    bit t, acc, ok;
    int a = 90;
    int prev = 90;
    int n = 0;
    do_reset();
    while (a > 0) begin
      a = (a > 4) ? a - 4 : 0;
      exp_q.push_back(a);
    end
    send(1, 0, ok);
    for (int c = 0; c < 80 * DUR && m_busy(1); c++) begin
      clk_step(1, 0, 0, t, acc);
      if (t) begin
        n++;
        if (int'(ca_b) != prev) begin
          got_q.push_back(int'(ca_b));
          prev = int'(ca_b);
          checks++;
          if (n % 3 != 0) begin
            errors++;
            $display("FAIL step4_cadence: tick %0d expected multiple of 3",
                     n);
          end
        end
        checks++;
        if (ca_b !== 8'(m_cur[1]) || hd_b !== 32'(m_high[1])) begin
          errors++;
          $display("FAIL step4_tick: got %0d/%0d expected %0d/%0d",
                   ca_b, hd_b, m_cur[1], m_high[1]);
        end
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL step4_len: got %0d expected %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL step4_seq%0d: got %0d expected %0d",
                 i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (hd_b !== 32'd25000 || ca_b !== 8'd0) begin
      errors++;
      $display("FAIL step4_end: got %0d/%0d expected 0/25000",
               ca_b, hd_b);
    end
  endtask

  task automatic test_retarget();
    int exp_cur[5] = '{91, 92, 93, 94, 95};
    bit t, acc, ok, ok2;
    int n = 0;
    do_reset();
    send(0, 95, ok);
    for (int c = 0; c < 4 * DUR && m_cur[0] != 92; c++)
      clk_step(0, 0, 0, t, acc);
    send(0, 0, ok);
    ok2 = 1;
    for (int c = 0; c < 7 * DUR && n < 5; c++) begin
      clk_step(0, 0, 0, t, acc);
      if (t) begin
        checks++;
        if (ca_a !== 8'(exp_cur[n]) || ca_a !== 8'(m_cur[0])) begin
          errors++;
          $display("FAIL retarget_tick%0d: got %0d expected %0d",
                   n, ca_a, exp_cur[n]);
        end
        if (n == 0) send(0, 95, ok2);
        n++;
      end
    end
    checks++;
    if (!ok || !ok2 || n != 5) begin
      errors++;
      $display("FAIL retarget_flow: got %0d ticks expected 5", n);
    end
    for (int c = 0; c < 3 * DUR && m_busy(0); c++)
      clk_step(0, 0, 0, t, acc);
    checks++;
    if (hd_a !== 32'd77725) begin
      errors++;
      $display("FAIL retarget_end: got %0d expected 77725", hd_a);
    end
  endtask

  task automatic test_reset_calc();
    bit t, acc, ok;
    int n = 0;
    do_reset();
    send(0, 100, ok);
    for (int c = 0; c < 2 * DUR && n == 0; c++) begin
      clk_step(0, 0, 0, t, acc);
      if (t) n++;
    end
    clk_step(0, 0, 0, t, acc);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ca_a !== 8'd90 || hd_a !== 32'd74950 || bz_a !== 1'b0
        || ifa.tgt_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got %0d/%0d/%0b/%0b expected 90/74950/0/1",
               ca_a, hd_a, bz_a, ifa.tgt_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 2 * DUR + 5; c++) begin
      clk_step(0, 0, 0, t, acc);
      if (t) begin
        checks++;
        if (hd_a !== 32'd74950 || ca_a !== 8'd90 || bz_a !== 1'b0)
        begin
          errors++;
          $display("FAIL stale_pending: got %0d/%0d/%0b expected 74950/90/0",
                   hd_a, ca_a, bz_a);
        end
      end
    end
  endtask

  task automatic test_random();
    bit t, acc, ok;
    int a, gap;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      a = $urandom_range(120, 60);
      send(0, a, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_accept: got timeout expected accept");
      end
      gap = $urandom_range(500, 20);
      for (int g = 0; g < gap; g++) begin
        clk_step(0, 0, 0, t, acc);
        if (t) begin
          checks++;
          if (ca_a !== 8'(m_cur[0]) || hd_a !== 32'(m_high[0])
              || bz_a !== m_busy(0)) begin
            errors++;
            $display("FAIL rand_tick: got %0d/%0d/%0b expected %0d/%0d/%0b",
                     ca_a, hd_a, bz_a,
                     m_cur[0], m_high[0], m_busy(0));
          end
        end
      end
    end
    for (int c = 0; c < 80 * DUR && m_busy(0); c++)
      clk_step(0, 0, 0, t, acc);
    checks++;
    if (ca_a !== 8'(m_cur[0]) || hd_a !== 32'(pulse(m_cur[0]))
        || bz_a !== 1'b0) begin
      errors++;
      $display("FAIL rand_end: got %0d/%0d/%0b expected %0d/%0d/0",
               ca_a, hd_a, bz_a, m_cur[0], pulse(m_cur[0]));
    end
  endtask

  initial begin
    ifa.tgt_valid = 1'b0;
    ifb.tgt_valid = 1'b0;
    ifa.tgt_angle = 8'd0;
    ifb.tgt_angle = 8'd0;
    test_reset();
    test_frame();
    test_basic();
    test_clamp();
    test_step4();
    test_retarget();
    test_reset_calc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
